// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with a programmable modulus, wrap or
// saturate at the limits, a parallel load, a registered terminal-count
// pulse and sticky overflow/underflow flags.
//
// Update priority on every rising clk edge: rst > load > en > hold.
// The legal count range is 0..modulus inclusive. A count above modulus
// (for example after modulus is lowered on the fly) snaps to modulus on
// the next enabled step. That snap is a range correction, not a boundary
// event, so it raises no flag and no tc.

module param_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             updo,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] modulus,
  input  logic             sat_mode,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH-1:0] CNT_RST  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic             out_of_range;
  logic             at_top;
  logic             at_bottom;
  logic             up_event;
  logic             down_event;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_dec;
  logic [WIDTH-1:0] up_next;
  logic [WIDTH-1:0] down_next;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;
  logic             udf_nxt;

  // Position of the current count relative to the live modulus.
  always_comb begin
    out_of_range = (count > modulus);
    at_top       = (count == modulus);
    at_bottom    = (count == CNT_ZERO);
  end

  // Boundary events. With modulus 0 the count sits at both limits, so
  // every enabled step is an event in whichever direction is selected.
  always_comb begin
    up_event   = en && !load && updo  && !out_of_range && at_top;
    down_event = en && !load && !updo && !out_of_range && at_bottom;
  end

  // Candidate values for each kind of step. The step sums stay WIDTH bits
  // wide, and the boundary cases never use the wrapped sum.
  always_comb begin
    load_clamped = (load_val > modulus) ? modulus : load_val;
    cnt_inc      = count + CNT_ONE;
    cnt_dec      = count - CNT_ONE;
    up_next      = at_top    ? (sat_mode ? modulus : CNT_ZERO) : cnt_inc;
    down_next    = at_bottom ? (sat_mode ? CNT_ZERO : modulus) : cnt_dec;
  end

  // Next count, following the load > enable > hold priority.
  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = load_clamped;
    end else if (en) begin
      if (out_of_range) begin
        count_nxt = modulus;
      end else if (updo) begin
        count_nxt = up_next;
      end else begin
        count_nxt = down_next;
      end
    end
  end

  // Flag and pulse next state. A new event wins over a simultaneous clear,
  // so the clear is applied first and the event may set the flag again.
  always_comb begin
    tc_nxt  = up_event || down_event;
    ovf_nxt = ovf;
    udf_nxt = udf;
    if (clr_flags) begin
      ovf_nxt = 1'b0;
      udf_nxt = 1'b0;
    end
    if (up_event) begin
      ovf_nxt = 1'b1;
    end
    if (down_event) begin
      udf_nxt = 1'b1;
    end
  end

  // Single register stage. Reset is synchronous and overrides everything,
  // which also drops any boundary event that was pending on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= CNT_RST;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      ovf   <= ovf_nxt;
      udf   <= udf_nxt;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter (WIDTH=4, RST_VAL=0).
// A behavioural model computes count and flags with plain integer
// arithmetic. A negedge process compares the DUT against that model on
// every cycle. Directed scenarios pin both DUT and model to literal values,
// and a randomized phase follows them.

module tb_param_updown_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         updo;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] modulus;
  logic         sat_mode;
  logic         clr_flags;
  logic [W-1:0] count;
  logic         tc;
  logic         ovf;
  logic         udf;

  int checks   = 0;
  int failures = 0;

  int m_cnt   = 0;
  bit m_tc    = 1'b0;
  bit m_ovf   = 1'b0;
  bit m_udf   = 1'b0;
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(W), .RST_VAL(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .updo      (updo),
    .load      (load),
    .load_val  (load_val),
    .modulus   (modulus),
    .sat_mode  (sat_mode),
    .clr_flags (clr_flags),
    .count     (count),
    .tc        (tc),
    .ovf       (ovf),
    .udf       (udf)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model. The legal range 0..mod is treated as a ring of
  // mod+1 values when wrapping, and as a clamp when saturating.
  always @(posedge clk) begin : model
    int mod;
    int lv;
    int nc;
    bit ev_o;
    bit ev_u;
    mod  = int'(modulus);
    lv   = int'(load_val);
    nc   = m_cnt;
    ev_o = 1'b0;
    ev_u = 1'b0;
    if (rst) begin
      m_cnt   = 0;
      m_tc    = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (load) begin
        nc = (lv < mod) ? lv : mod;
      end else if (en) begin
        if (m_cnt > mod) begin
          nc = mod;
        end else if (updo) begin
          ev_o = (m_cnt == mod);
          nc   = sat_mode ? ((m_cnt + 1 > mod) ? mod : m_cnt + 1)
                          : (m_cnt + 1) % (mod + 1);
        end else begin
          ev_u = (m_cnt == 0);
          nc   = sat_mode ? ((m_cnt == 0) ? 0 : m_cnt - 1)
                          : (m_cnt + mod) % (mod + 1);
        end
      end
      m_cnt = nc;
      m_tc  = ev_o | ev_u;
      if (clr_flags) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (ev_o) m_ovf = 1'b1;
      if (ev_u) m_udf = 1'b1;
    end
  end

  // Compare the DUT against the model on every cycle after the first reset.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_count", int'(count), m_cnt);
      chk("model_tc",    int'(tc),    int'(m_tc));
      chk("model_ovf",   int'(ovf),   int'(m_ovf));
      chk("model_udf",   int'(udf),   int'(m_udf));
    end
  end

  initial begin
    int seq33 [7] = '{5, 4, 3, 2, 1, 0, 5};

    rst = 1'b1; en = 1'b0; updo = 1'b1; load = 1'b0; load_val = '0;
    modulus = 4'd15; sat_mode = 1'b0; clr_flags = 1'b0;

    // Reset, then a full wrapping up-count.
    cyc(2);
    chk("rst_count", int'(count), 0);
    chk("rst_tc",    int'(tc),    0);
    chk("rst_ovf",   int'(ovf),   0);
    chk("rst_udf",   int'(udf),   0);
    rst = 1'b0; en = 1'b1; updo = 1'b1; modulus = 4'd15; sat_mode = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      cyc(1);
      chk("wrap_up_count", int'(count), k % 16);
      chk("wrap_up_tc",    int'(tc),    (k == 16) ? 1 : 0);
    end
    chk("wrap_up_ovf", int'(ovf), 1);
    chk("wrap_up_model_ovf", int'(m_ovf), 1);
    chk("wrap_up_model_cnt", m_cnt, 1);

    // Load above modulus clamps; saturating up holds at the top.
    en = 1'b0; modulus = 4'd9; sat_mode = 1'b1; load = 1'b1; load_val = 4'd12;
    cyc(1);
    chk("load_clamp_count", int'(count), 9);
    chk("load_clamp_tc",    int'(tc),    0);
    chk("load_clamp_model", m_cnt, 9);
    load = 1'b0; en = 1'b1; updo = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("sat_up_count", int'(count), 9);
      chk("sat_up_tc",    int'(tc),    1);
      chk("sat_up_ovf",   int'(ovf),   1);
    end
    en = 1'b0; clr_flags = 1'b1;
    cyc(1);
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_tc",  int'(tc),  0);
    clr_flags = 1'b0; en = 1'b1;
    cyc(1);
    chk("reset_ovf_again", int'(ovf), 1);
    chk("reset_tc_again",  int'(tc),  1);

    // Wrapping down-count from 0 with modulus 5.
    en = 1'b0; load = 1'b1; load_val = 4'd0; modulus = 4'd5; sat_mode = 1'b0;
    cyc(1);
    chk("load0_count", int'(count), 0);
    load = 1'b0; en = 1'b1; updo = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      chk("wrap_dn_count", int'(count), seq33[i]);
      chk("wrap_dn_tc",    int'(tc),    (i == 0 || i == 6) ? 1 : 0);
    end
    chk("wrap_dn_udf", int'(udf), 1);
    chk("wrap_dn_ovf", int'(ovf), 1);
    chk("wrap_dn_model_cnt", m_cnt, 5);

    // Modulus lowered below the live count: snap with no event.
    en = 1'b0; load = 1'b1; load_val = 4'd12; modulus = 4'd15; clr_flags = 1'b1;
    cyc(1);
    chk("oor_pre_count", int'(count), 12);
    chk("oor_pre_udf",   int'(udf),   0);
    load = 1'b0; clr_flags = 1'b0; modulus = 4'd7; en = 1'b1; updo = 1'b0;
    cyc(1);
    chk("oor_count", int'(count), 7);
    chk("oor_tc",    int'(tc),    0);
    chk("oor_udf",   int'(udf),   0);

    // Wrap coinciding with clr_flags: the new event wins.
    en = 1'b0; load = 1'b1; load_val = 4'd15; modulus = 4'd15;
    cyc(1);
    load = 1'b0; en = 1'b1; updo = 1'b1;
    cyc(1);
    chk("pre_clr_ovf", int'(ovf), 1);
    en = 1'b0; load = 1'b1;
    cyc(1);
    chk("reload_count", int'(count), 15);
    chk("reload_tc",    int'(tc),    0);
    load = 1'b0; en = 1'b1; updo = 1'b1; clr_flags = 1'b1;
    cyc(1);
    chk("clr_event_count", int'(count), 0);
    chk("clr_event_ovf",   int'(ovf),   1);
    chk("clr_event_tc",    int'(tc),    1);
    clr_flags = 1'b0;

    // Reset overrides load and a pending wrap.
    en = 1'b0; load = 1'b1; load_val = 4'd15;
    cyc(1);
    rst = 1'b1; load = 1'b1; load_val = 4'd6; en = 1'b1; updo = 1'b1;
    cyc(1);
    chk("rst_prio_count", int'(count), 0);
    chk("rst_prio_tc",    int'(tc),    0);
    chk("rst_prio_ovf",   int'(ovf),   0);
    chk("rst_prio_udf",   int'(udf),   0);

    // Modulus 0: every enabled step is an event.
    rst = 1'b0; load = 1'b0; modulus = 4'd0; en = 1'b1; updo = 1'b0; sat_mode = 1'b0;
    cyc(1);
    chk("mod0_dn_count", int'(count), 0);
    chk("mod0_dn_tc",    int'(tc),    1);
    chk("mod0_dn_udf",   int'(udf),   1);
    updo = 1'b1;
    cyc(1);
    chk("mod0_up_tc",  int'(tc),  1);
    chk("mod0_up_ovf", int'(ovf), 1);

    // Reset raised mid-cycle must not act until the next rising edge.
    en = 1'b0; modulus = 4'd15; load = 1'b1; load_val = 4'd5;
    cyc(1);
    load = 1'b0; rst = 1'b1;
    #2;
    chk("rst_sync_hold", int'(count), 5);
    cyc(1);
    chk("rst_sync_apply", int'(count), 0);
    rst = 1'b0;

    // Randomized phase, biased toward small moduli and sticky directions.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) < 2);
      load      = ($urandom_range(0, 15) == 0);
      en        = ($urandom_range(0, 3) != 0);
      load_val  = W'($urandom);
      clr_flags = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) updo = ~updo;
      if ($urandom_range(0, 7) == 0) sat_mode = ~sat_mode;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0:       modulus = 4'd0;
          1:       modulus = 4'd1;
          default: modulus = W'($urandom);
        endcase
      end
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
